onchip_mem_copy_master: RTL and testbench
=========================================

// Module: onchip_mem_copy_master
// PURPOSE
//  Avalon-MM master that drives the single-port on-chip RAM (2048 x 32, byte-enabled) from the other end.
//  Given a command, it either copies a block of words (COPY) or fills a block with a constant (FILL).
//  Used to clear and initialise board-state tables and to snapshot them without Nios software loops.
//  Sits between a control register block (cmd side) and a RAM slave port through the fabric.
// PARAMETERS
//  ADDR_W        11  word address width; addresses wrap modulo 2**ADDR_W
//  DATA_W        32  data width; byteenable width is DATA_W/8
//  READ_LATENCY  1   fixed cycles from read acceptance to valid avm_readdata (range 1..3)
// PORTS
//  clk              in   1          system clock
//  reset_n          in   1          asynchronous active-low reset
//  start            in   1          one-cycle command strobe; sampled only in IDLE
//  mode             in   1          0 = COPY, 1 = FILL; latched on start
//  src_addr         in   ADDR_W     COPY source word address; latched on start
//  dst_addr         in   ADDR_W     destination word address; latched on start
//  word_count       in   ADDR_W+1   words to transfer, 0..2048; latched on start
//  fill_data        in   DATA_W     FILL pattern; latched on start
//  busy             out  1          high from the cycle after start until done
//  done             out  1          one-cycle pulse when the command completes
//  avm_address      out  ADDR_W     word address to the RAM
//  avm_chipselect   out  1          high whenever avm_read or avm_write is high
//  avm_read         out  1          read request
//  avm_write        out  1          write request
//  avm_byteenable   out  DATA_W/8   all ones whenever avm_write is high, else 0
//  avm_writedata    out  DATA_W     write data
//  avm_readdata     in   DATA_W     read data, valid READ_LATENCY cycles after an accepted read
//  avm_waitrequest  in   1          stall; a request is accepted in a cycle where it is high and waitrequest is low
// BEHAVIOUR
//  Reset: the FSM goes to IDLE. busy, done, avm_read, avm_write, avm_chipselect and avm_byteenable are 0.
//   avm_address and avm_writedata are also 0. All internal counters clear.
//  States: IDLE, RD, RD_WAIT, WR, DONE.
//  IDLE: on start, latch the command and clear idx.
//   word_count == 0 -> DONE. mode == FILL -> WR. Otherwise -> RD.
//  RD: avm_read = 1 and avm_address = src + idx.
//   Hold both until accepted (waitrequest low), then -> RD_WAIT.
//  RD_WAIT: count READ_LATENCY cycles.
//   In the last of these cycles, capture avm_readdata into the data register, then -> WR.
//  WR: avm_write = 1, avm_address = dst + idx, avm_writedata = data register (COPY) or fill_data latch (FILL).
//   Hold address and data stable until accepted.
//   On acceptance, idx increments. If idx+1 == count -> DONE; else -> RD (COPY) or WR (FILL).
//  DONE: done = 1 for exactly one cycle, busy = 0, -> IDLE. A start in the DONE cycle is ignored.
//  busy is a registered output: high in every state except IDLE and DONE.
//  start is ignored while busy. Command inputs are don't-care except in the start cycle.
//  Address arithmetic is ADDR_W bits and wraps: src + idx and dst + idx are taken mod 2**ADDR_W.
//  Overlapping copies run in ascending order, word by word (read then write).
//   Consequence: if dst = src + k with k > 0 and k < count, the first k words are replicated.
//   This is the defined behaviour, not an error.
//  avm_read and avm_write are never high in the same cycle. There is at most one outstanding read.
//  Throughput with waitrequest low:
//   COPY = (2 + READ_LATENCY) cycles per word.
//   FILL = 1 cycle per word (back-to-back writes).
//  Each waitrequest cycle adds exactly one stall cycle.
//  reset_n asserted mid-command: all outputs drop asynchronously and no done pulse is issued.
//   The command is abandoned; the RAM may hold a partial transfer.
// TESTING
//  1. FILL, dst=0x010, count=4, data=0xDEADBEEF, no waitrequest.
//     -> writes to 0x010..0x013 on 4 consecutive cycles, byteenable=4'hF, then done 1 cycle later.
//  2. COPY, src=0x000 (preloaded 1,2,3), dst=0x100, count=3, READ_LATENCY=1.
//     -> RAM 0x100..0x102 = 1,2,3; done 9 cycles after the first RD cycle.
//  3. COPY, src=0x7FE, dst=0x7FF, count=3.
//     -> reads 0x7FE, 0x7FF, 0x000; writes 0x7FF, 0x000, 0x001 (wrap); end state is forward replication.
//  4. word_count=0 -> no avm_read/avm_write; done pulses the cycle after start; busy stays 0.
//  5. FILL, count=2, waitrequest held high for 3 cycles on the first write.
//     -> address and data stable across the stall; exactly 2 writes; done once.
//  6. Reset mid-COPY (after 2 of 5 words) -> outputs 0 immediately, no done.
//     A new FILL after reset completes normally. A start during busy has no effect.

Source files
------------

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master that copies a block of RAM words or fills a block with a constant.
// One word at a time: read (COPY only), wait fixed read latency, write; addresses wrap.
module onchip_mem_copy_master #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [ADDR_W:0]     word_count_i,
    input  logic [DATA_W-1:0]   fill_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W-1:0]   avm_address_o,
    output logic                avm_chipselect_o,
    output logic                avm_read_o,
    output logic                avm_write_o,
    output logic [DATA_W/8-1:0] avm_byteenable_o,
    output logic [DATA_W-1:0]   avm_writedata_o,
    input  logic [DATA_W-1:0]   avm_readdata_i,
    input  logic                avm_waitrequest_i
);

    typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StDone} state_e;

    localparam logic [1:0]      LatLast = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_W:0] IdxOne  = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          lat_q, lat_d;
    logic                busy_q, busy_d;
    logic                last_word;

    assign last_word = (idx_q + IdxOne) == count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        data_d  = data_q;
        lat_d   = lat_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    count_d = word_count_i;
                    fill_d  = fill_data_i;
                    idx_d   = '0;
                    if (word_count_i == '0) begin
                        state_d = StDone;
                    end else if (mode_i) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (!avm_waitrequest_i) begin
                    lat_d   = '0;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                // Read data is valid only in the final latency cycle.
                if (lat_q == LatLast) begin
                    data_d  = avm_readdata_i;
                    state_d = StWr;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StWr: begin
                if (!avm_waitrequest_i) begin
                    idx_d = idx_q + IdxOne;
                    if (last_word) begin
                        state_d = StDone;
                    end else if (mode_q) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRd) || (state_d == StRdWait) || (state_d == StWr);
    end

    always_comb begin
        avm_read_o      = 1'b0;
        avm_write_o     = 1'b0;
        avm_address_o   = '0;
        avm_writedata_o = '0;
        unique case (state_q)
            StRd: begin
                avm_read_o    = 1'b1;
                avm_address_o = src_q + idx_q[ADDR_W-1:0];
            end
            StWr: begin
                avm_write_o     = 1'b1;
                avm_address_o   = dst_q + idx_q[ADDR_W-1:0];
                avm_writedata_o = mode_q ? fill_q : data_q;
            end
            default: ;
        endcase
    end

    assign avm_chipselect_o = avm_read_o | avm_write_o;
    assign avm_byteenable_o = {(DATA_W / 8){avm_write_o}};
    assign done_o           = (state_q == StDone);
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Bench for onchip_mem_copy_master: RAM slave model, block-level reference model and a
// scoreboard that matches every accepted read/write and done pulse against expectations.
module tb_onchip_mem_copy_master;

    localparam int unsigned AW     = 11;
    localparam int unsigned DW     = 32;
    localparam int unsigned RL     = 1;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam int unsigned BUDGET = 20000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, mode;
    logic [AW-1:0] src, dst;
    logic [AW:0]   cnt;
    logic [DW-1:0] fill;
    logic          busy, done;
    logic [AW-1:0] avm_address;
    logic          avm_cs, avm_rd, avm_wr;
    logic [DW/8-1:0] avm_be;
    logic [DW-1:0] avm_wdata, avm_rdata;
    logic          avm_wait;

    logic [DW-1:0]    ram     [DEPTH];
    logic [DW-1:0]    ref_mem [DEPTH];
    logic [AW+DW-1:0] exp_wr_q [$];
    logic [AW-1:0]    exp_rd_q [$];
    int               done_exp, done_seen, n_pass, n_chk, arm_stall;
    bit               rand_en, stray_en;

    always #5 clk = ~clk;

    onchip_mem_copy_master #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .mode_i            (mode),
        .src_addr_i        (src),
        .dst_addr_i        (dst),
        .word_count_i      (cnt),
        .fill_data_i       (fill),
        .busy_o            (busy),
        .done_o            (done),
        .avm_address_o     (avm_address),
        .avm_chipselect_o  (avm_cs),
        .avm_read_o        (avm_rd),
        .avm_write_o       (avm_wr),
        .avm_byteenable_o  (avm_be),
        .avm_writedata_o   (avm_wdata),
        .avm_readdata_i    (avm_rdata),
        .avm_waitrequest_i (avm_wait)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_read"},  64'(avm_rd), 64'(0));
        check({tag, "_write"}, 64'(avm_wr), 64'(0));
        check({tag, "_cs"},    64'(avm_cs), 64'(0));
        check({tag, "_be"},    64'(avm_be), 64'(0));
        check({tag, "_addr"},  64'(avm_address), 64'(0));
        check({tag, "_wdata"}, 64'(avm_wdata), 64'(0));
    endtask

    // Reference: a block transfer is a word-by-word ascending copy/fill with wrapping addresses.
    task automatic model(input bit m, input int unsigned s, input int unsigned d,
                         input int unsigned c, input logic [DW-1:0] f);
        for (int unsigned i = 0; i < c; i++) begin
            int unsigned   sa = (s + i) % DEPTH;
            int unsigned   da = (d + i) % DEPTH;
            logic [DW-1:0] v;
            v = m ? f : ref_mem[sa];
            if (!m) exp_rd_q.push_back(AW'(sa));
            ref_mem[da] = v;
            exp_wr_q.push_back({AW'(da), v});
        end
        done_exp++;
    endtask

    function automatic int exp_lat(input bit m, input int unsigned c);
        if (c == 0) return 1;
        return m ? int'(c) + 1 : int'(c) * (2 + RL) + 1;
    endfunction

    // RAM slave plus monitor; everything is decided at the falling edge for the next rising edge.
    task automatic bus_model();
        logic [DW-1:0] pend;
        logic          w, pstall;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic [AW+DW-1:0] e;
        pstall = 1'b0;
        pend   = '0;
        forever begin
            @(negedge clk);
            w = (rand_en && ($urandom_range(3) == 0)) || (avm_wr && arm_stall > 0);
            avm_wait  = w;
            avm_rdata = pend;
            pend      = $urandom;
            if (rst_n) begin
                check("rd_wr_exclusive", 64'(avm_rd & avm_wr), 64'(0));
                check("chipselect", 64'(avm_cs), 64'(avm_rd | avm_wr));
                check("byteenable", 64'(avm_be), avm_wr ? 64'hF : 64'h0);
                if (pstall) begin
                    check("stall_hold_write", 64'(avm_wr), 64'(1));
                    check("stall_hold_addr", 64'(avm_address), 64'(pa));
                    check("stall_hold_data", 64'(avm_wdata), 64'(pd));
                end
                pstall = avm_wr && w;
                pa     = avm_address;
                pd     = avm_wdata;
                if (avm_rd && !w) begin
                    n_chk++;
                    if (exp_rd_q.size() == 0) begin
                        $display("FAIL read_addr: actual %0h required none", avm_address);
                    end else begin
                        pa = exp_rd_q.pop_front();
                        if (avm_address === pa) n_pass++;
                        else $display("FAIL read_addr: actual %0h required %0h", avm_address, pa);
                    end
                    pend = ram[avm_address];
                end
                if (avm_wr && !w) begin
                    n_chk++;
                    if (exp_wr_q.size() == 0) begin
                        $display("FAIL write: actual %0h/%0h required none", avm_address, avm_wdata);
                    end else begin
                        e = exp_wr_q.pop_front();
                        if ({avm_address, avm_wdata} === e) n_pass++;
                        else $display("FAIL write: actual %0h/%0h required %0h/%0h",
                                      avm_address, avm_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                    end
                    ram[avm_address] = avm_wdata;
                end
                if (done) begin
                    n_chk++;
                    if (done_seen < done_exp) n_pass++;
                    else $display("FAIL done_pulse: actual extra done required %0d", done_exp);
                    done_seen++;
                end
            end else begin
                pstall = 1'b0;
            end
            if (avm_wr && arm_stall > 0) arm_stall--;
        end
    endtask

    task automatic run_cmd(input bit m, input int unsigned s, input int unsigned d,
                           input int unsigned c, input logic [DW-1:0] f, output int lat);
        bit busy_ok;
        int diff;
        busy_ok = 1'b1;
        diff    = 0;
        model(m, s, d, c, f);
        start = 1'b1;
        mode  = m;
        src   = AW'(s);
        dst   = AW'(d);
        cnt   = (AW + 1)'(c);
        fill  = f;
        @(negedge clk);
        lat = 1;
        start = 1'b0;
        while (!done && lat < int'(BUDGET)) begin
            if (!busy) busy_ok = 1'b0;
            start = stray_en && busy && ($urandom_range(5) == 0);
            mode  = 1'($urandom);
            src   = AW'($urandom);
            dst   = AW'($urandom);
            cnt   = (AW + 1)'($urandom_range(DEPTH));
            fill  = $urandom;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_within_budget", 64'(done), 64'(1));
        check("busy_window", 64'(busy_ok), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
        @(negedge clk);
        check("done_width", 64'(done), 64'(0));
        check("done_count", 64'(done_seen), 64'(done_exp));
        check("writes_left", 64'(exp_wr_q.size()), 64'(0));
        check("reads_left", 64'(exp_rd_q.size()), 64'(0));
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ref_mem[i]) diff++;
        check("ram_image", 64'(diff), 64'(0));
    endtask

    initial begin
        int            lat;
        bit            m;
        int unsigned   s, d, c;
        logic [DW-1:0] v0, w1, old2;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; cnt = '0; fill = '0;
        avm_wait = 1'b0; avm_rdata = '0;
        rand_en = 1'b0; stray_en = 1'b0; arm_stall = 0;
        done_exp = 0; done_seen = 0; n_pass = 0; n_chk = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        fork
            bus_model();
        join_none
        #3;
        check_quiet("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FILL back-to-back
        run_cmd(1'b1, 'h010, 'h010, 4, 32'hDEADBEEF, lat);
        check("fill4_latency", 64'(lat), 64'(5));

        // COPY of 1,2,3
        for (int i = 0; i < 3; i++) begin
            ram[i]     = DW'(i + 1);
            ref_mem[i] = DW'(i + 1);
        end
        run_cmd(1'b0, 'h000, 'h100, 3, '0, lat);
        check("copy3_latency", 64'(lat), 64'(10));
        for (int i = 0; i < 3; i++) check("copy3_data", 64'(ram['h100 + i]), 64'(i + 1));

        // Overlapping copy across the wrap point replicates the first word forward
        v0 = ram['h7FE];
        run_cmd(1'b0, 'h7FE, 'h7FF, 3, '0, lat);
        check("wrap_7ff", 64'(ram['h7FF]), 64'(v0));
        check("wrap_000", 64'(ram['h000]), 64'(v0));
        check("wrap_001", 64'(ram['h001]), 64'(v0));

        // Zero-length command
        run_cmd(1'b0, 'h123, 'h456, 0, '0, lat);
        check("zero_latency", 64'(lat), 64'(1));

        // Write stalled three cycles
        arm_stall = 3;
        run_cmd(1'b1, 'h040, 'h040, 2, 32'hA5A5_0F0F, lat);
        check("stall_latency", 64'(lat), 64'(6));

        // Reset in the middle of a 5-word COPY, after two words are written
        old2 = ram['h302];
        model(1'b0, 'h200, 'h300, 5, '0);
        w1 = ref_mem['h301];
        start = 1'b1; mode = 1'b0; src = AW'('h200); dst = AW'('h300); cnt = (AW + 1)'(5);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && exp_wr_q.size() > 3; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_quiet("midreset");
        check("partial_word1", 64'(ram['h301]), 64'(w1));
        check("partial_word2", 64'(ram['h302]), 64'(old2));
        exp_wr_q.delete();
        exp_rd_q.delete();
        done_exp--;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = ram[i];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", 64'(done_seen), 64'(done_exp));

        // FILL after reset, with stray starts while busy
        stray_en = 1'b1;
        run_cmd(1'b1, 'h500, 'h500, 20, 32'h1234_5678, lat);
        check("post_reset_fill_latency", 64'(lat), 64'(21));

        // Full-memory FILL
        run_cmd(1'b1, 0, $urandom_range(DEPTH - 1), DEPTH, $urandom, lat);
        check("full_fill_latency", 64'(lat), 64'(DEPTH + 1));

        // Randomised commands
        for (int n = 0; n < 40; n++) begin
            m = 1'($urandom);
            c = ($urandom_range(9) == 0) ? 0 : $urandom_range(24, 1);
            s = $urandom_range(DEPTH - 1);
            if ($urandom_range(3) == 0) d = (s + $urandom_range(c + 1, 1)) % DEPTH;
            else d = $urandom_range(DEPTH - 1);
            rand_en = 1'($urandom);
            run_cmd(m, s, d, c, $urandom, lat);
            if (!rand_en) check("rand_latency", 64'(lat), 64'(exp_lat(m, c)));
        end
        rand_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
